// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES encryption round controller, one round per clock
module aes_round_sequencer #(
    parameter int NROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits 8*(255-b)+7 down to 8*(255-b), i.e. index {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    // Byte r+4c holds row r, column c; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic [127:0] sr_state;
    logic [127:0] full_round;
    logic [127:0] final_round;

    assign sr_state    = shift_rows(sub_bytes(state_q));
    assign full_round  = mix_columns(sr_state) ^ rk_data_i;
    assign final_round = sr_state ^ rk_data_i;

    always_comb begin
        fsm_d       = fsm_q;
        round_d     = round_q;
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    state_d    = in_data_i ^ rk_data_i;
                    round_d    = 4'd1;
                    fsm_d      = S_ROUND;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_ROUND: begin
                if (round_q == LAST_ROUND) begin
                    state_d     = final_round;
                    fsm_d       = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = full_round;
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    fsm_d       = S_IDLE;
                    round_d     = 4'd0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                fsm_d       = S_IDLE;
                round_d     = 4'd0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fsm_q       <= S_IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            round_q     <= round_d;
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign out_data_o  = state_q;
    assign rk_idx_o    = (fsm_q == S_ROUND) ? round_q : 4'd0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed scoreboard bench for AES-128 and AES-256 sequencers
module tb_aes_round_sequencer;

    localparam logic [2047:0] SBOX_TB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         busy      [2];
    logic [127:0] in_data   [2];
    logic [127:0] rk_data   [2];
    logic [127:0] out_data  [2];
    logic [3:0]   rk_idx    [2];
    logic [127:0] rk        [2][16];
    logic [127:0] sb_q      [$];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    assign rk_data[0] = rk[0][rk_idx[0]];
    assign rk_data[1] = rk[1][rk_idx[1]];

    aes_round_sequencer #(.NROUNDS(10)) u_aes128 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .rk_idx_o(rk_idx[0]), .rk_data_i(rk_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
        .busy_o(busy[0])
    );

    aes_round_sequencer #(.NROUNDS(14)) u_aes256 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .rk_idx_o(rk_idx[1]), .rk_data_i(rk_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
        .busy_o(busy[1])
    );

    function automatic logic [7:0] sb(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TB[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // FIPS-197 key expansion; nk = 4 for AES-128, 8 for AES-256 (key left-aligned).
    task automatic load_key(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[d][r] = '0;
        for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [127:0] pt, input logic [127:0] exp, input string tag);
        chk({tag, "_idle_ready"}, 128'(in_ready[d]), 128'd1);
        chk({tag, "_idle_rk_idx"}, 128'(rk_idx[d]), 128'd0);
        in_data[d]  = pt;
        in_valid[d] = 1'b1;
        sb_q.push_back(exp);
        tick();
        in_valid[d] = 1'b0;
        chk({tag, "_accept_busy"}, 128'(busy[d]), 128'd1);
        chk({tag, "_accept_in_ready"}, 128'(in_ready[d]), 128'd0);
    endtask

    // Called right after the accept edge; checks rk_idx per round, latency and ciphertext.
    task automatic wait_out(input int d, input int nr, input string tag);
        int           cyc;
        logic [127:0] exp;
        cyc = 0;
        while (!out_valid[d] && cyc < 40) begin
            chk({tag, "_rk_idx"}, 128'(rk_idx[d]), 128'(cyc + 1));
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 128'(cyc), 128'(nr));
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk({tag, "_out_data"}, out_data[d], exp);
        end else begin
            tests++;
            fails++;
            $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
        end
    endtask

    task automatic handshake(input int d, input string tag);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
        chk({tag, "_post_in_ready"}, 128'(in_ready[d]), 128'd1);
        chk({tag, "_post_out_valid"}, 128'(out_valid[d]), 128'd0);
        chk({tag, "_post_busy"}, 128'(busy[d]), 128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in_data[d]   = '0;
        end
        load_key(0, {C1_KEY, 128'h0}, 4);
        load_key(1, C3_KEY, 8);
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst_busy", 128'(busy[0]), 128'd0);
        chk("rst_rk_idx", 128'(rk_idx[0]), 128'd0);
        chk("rst_out_data", out_data[0], 128'd0);
        rst_n = 1'b1;

        send(0, C1_PT, C1_CT, "c1");
        wait_out(0, 10, "c1");
        handshake(0, "c1");

        load_key(0, {B_KEY, 128'h0}, 4);
        send(0, B_PT, B_CT, "fipsb");
        wait_out(0, 10, "fipsb");
        in_data[0]  = C1_PT;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_data", out_data[0], B_CT);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
        end
        in_valid[0] = 1'b0;
        handshake(0, "bp");

        // Back-to-back: in_valid and out_ready held; key store swapped once block one is done.
        load_key(0, {C1_KEY, 128'h0}, 4);
        out_ready[0] = 1'b1;
        in_data[0]   = C1_PT;
        in_valid[0]  = 1'b1;
        sb_q.push_back(C1_CT);
        tick();
        in_data[0] = B_PT;
        sb_q.push_back(B_CT);
        wait_out(0, 10, "b2b1");
        load_key(0, {B_KEY, 128'h0}, 4);
        tick();
        chk("b2b_hs_in_ready", 128'(in_ready[0]), 128'd1);
        chk("b2b_hs_out_valid", 128'(out_valid[0]), 128'd0);
        tick();
        chk("b2b_accept2_busy", 128'(busy[0]), 128'd1);
        chk("b2b_accept2_in_ready", 128'(in_ready[0]), 128'd0);
        in_valid[0] = 1'b0;
        wait_out(0, 10, "b2b2");
        tick();
        chk("b2b_end_out_valid", 128'(out_valid[0]), 128'd0);
        out_ready[0] = 1'b0;

        send(0, B_PT, B_CT, "midrst");
        tick();
        tick();
        tick();
        chk("midrst_round4_rk_idx", 128'(rk_idx[0]), 128'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        chk("midrst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("midrst_rk_idx", 128'(rk_idx[0]), 128'd0);
        load_key(0, {C1_KEY, 128'h0}, 4);
        send(0, C1_PT, C1_CT, "after_rst");
        wait_out(0, 10, "after_rst");
        handshake(0, "after_rst");

        send(1, C1_PT, C3_CT, "c3");
        wait_out(1, 14, "c3");
        handshake(1, "c3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
